legv8_control_unit: RTL

//  Multi-cycle sequencer for the 64-bit LEGv8 datapath. Fetches 32-bit instructions over a req/ack memory port,

---
 rtl/legv8_control_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer: fetch over req/ack, decode, drive the datapath control word, own the PC.
// Optional memory-wait timeout enabled by defining CU_MEM_TIMEOUT_EN.
module legv8_control_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [4:0]  FS_ADD      = 5'b01000,
  parameter logic [4:0]  FS_SUB      = 5'b01001,
  parameter logic [4:0]  FS_AND      = 5'b00000,
  parameter logic [4:0]  FS_ORR      = 5'b00100
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [3:0]  status,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic        W,
  output logic [4:0]  FS,
  output logic        C0,
  output logic        B_sel,
  output logic [63:0] constant,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_ADDR_ALU,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StHalt} state_e;
  typedef enum logic [2:0] {OpBad, OpR, OpI, OpB, OpCbz, OpLdur, OpStur} op_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] ir;
  op_e         op;
  logic [4:0]  fs_sel;
  logic        tmo_hit;

  logic [4:0]  rd, rn, rm;
  logic [63:0] imm_i, imm_d;
  logic [31:0] off_b, off_cbz;

  assign rd      = ir[4:0];
  assign rn      = ir[9:5];
  assign rm      = ir[20:16];
  assign imm_i   = {52'd0, ir[21:10]};
  assign imm_d   = {{55{ir[20]}}, ir[20:12]};
  assign off_b   = {{4{ir[25]}}, ir[25:0], 2'b00};
  assign off_cbz = {{11{ir[23]}}, ir[23:5], 2'b00};

  assign instr_addr = pc;
  assign halted     = (state == StHalt);

  logic unused_status;
  assign unused_status = ^status[3:1];

  always_comb begin
    op     = OpBad;
    fs_sel = FS_ADD;
    if (ir[31:21] == 11'b10001011000) begin
      op = OpR;
    end else if (ir[31:21] == 11'b11001011000) begin
      op     = OpR;
      fs_sel = FS_SUB;
    end else if (ir[31:21] == 11'b10001010000) begin
      op     = OpR;
      fs_sel = FS_AND;
    end else if (ir[31:21] == 11'b10101010000) begin
      op     = OpR;
      fs_sel = FS_ORR;
    end else if (ir[31:22] == 10'b1001000100) begin
      op = OpI;
    end else if (ir[31:22] == 10'b1101000100) begin
      op     = OpI;
      fs_sel = FS_SUB;
    end else if (ir[31:21] == 11'b11111000010) begin
      op = OpLdur;
    end else if (ir[31:21] == 11'b11111000000) begin
      op = OpStur;
    end else if (ir[31:24] == 8'b10110100) begin
      op = OpCbz;
    end else if (ir[31:26] == 6'b000101) begin
      op = OpB;
    end
  end

`ifdef CU_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  logic [CntW-1:0] tmo_cnt;
  logic            fault_q;
  logic            waiting;

  assign waiting = (state == StFetch || state == StMem) && !mem_ack;
  assign tmo_hit = waiting && (tmo_cnt == CntW'(MEM_TIMEOUT - 1));
  assign fault   = fault_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_cnt <= (waiting && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) fault_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_TIMEOUT == 0);
  assign tmo_hit    = 1'b0;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= StFetch;
      pc    <= RESET_PC;
      ir    <= '0;
    end else if (tmo_hit) begin
      state <= StHalt;
    end else begin
      unique case (state)
        StFetch: begin
          if (mem_ack) begin
            ir    <= instr_rdata;
            state <= StDecode;
          end
        end
        StDecode: begin
          if (op == OpBad)                        state <= StHalt;
          else if (op == OpLdur || op == OpStur)  state <= StMem;
          else                                    state <= StExec;
        end
        StExec: begin
          state <= StFetch;
          if (op == OpB)                        pc <= pc + off_b;
          else if (op == OpCbz && status[0])    pc <= pc + off_cbz;
          else                                  pc <= pc + 32'd4;
        end
        StMem: begin
          if (mem_ack) begin
            pc    <= pc + 32'd4;
            state <= StFetch;
          end
        end
        StHalt:  state <= StHalt;
        default: state <= StHalt;
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    DA          = 5'd0;
    SA          = 5'd0;
    SB          = 5'd0;
    W           = 1'b0;
    FS          = FS_AND;
    B_sel       = 1'b0;
    constant    = 64'd0;
    EN_ALU      = 1'b0;
    EN_B        = 1'b0;
    EN_ADDR_ALU = 1'b0;
    unique case (state)
      StFetch: mem_req = 1'b1;
      StExec: begin
        case (op)
          OpR: begin
            SA     = rn;
            SB     = rm;
            FS     = fs_sel;
            EN_ALU = 1'b1;
            DA     = rd;
            W      = 1'b1;
          end
          OpI: begin
            SA       = rn;
            B_sel    = 1'b1;
            constant = imm_i;
            FS       = fs_sel;
            EN_ALU   = 1'b1;
            DA       = rd;
            W        = 1'b1;
          end
          OpCbz: begin
            SA    = rd;
            B_sel = 1'b1;
            FS    = FS_ADD;
          end
          default: ;
        endcase
      end
      StMem: begin
        SA          = rn;
        B_sel       = 1'b1;
        constant    = imm_d;
        FS          = FS_ADD;
        EN_ADDR_ALU = 1'b1;
        mem_req     = 1'b1;
        if (op == OpStur) begin
          mem_we = 1'b1;
          SB     = rd;
          EN_B   = 1'b1;
        end else begin
          DA = rd;
          W  = mem_ack;
        end
      end
      default: ;
    endcase
    if (DA == 5'd31) W = 1'b0;
    C0 = (FS == FS_SUB);
    // Async reset must silence the memory port in the same cycle it is applied.
    if (!reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

endmodule
